// File: rtl/soc_mem_pkg.sv
// Shared data-memory encodings and lane helpers, reused by the core decoder
// and the data-memory responder.
package soc_mem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  localparam logic [7:0] IO_TOP8_DEF = 8'hC0;

  function automatic logic [3:0] store_be(logic [2:0] size, logic [1:0] off);
    case (size[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = off[1] ? 4'b1100 : 4'b0011;
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(logic [2:0] size, logic [31:0] wd);
    case (size[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(logic [31:0] word, logic [2:0] size,
                                              logic [1:0] off);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      MEM_B:   load_extend = {{24{sh[7]}}, sh[7:0]};
      MEM_H:   load_extend = {{16{sh[15]}}, sh[15:0]};
      MEM_BU:  load_extend = {24'b0, sh[7:0]};
      MEM_HU:  load_extend = {16'b0, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  // Illegal encodings first, then natural-alignment check.
  function automatic logic ld_fault(logic [2:0] size, logic [1:0] off);
    case (size)
      MEM_B, MEM_BU: ld_fault = 1'b0;
      MEM_H, MEM_HU: ld_fault = off[0];
      MEM_W:         ld_fault = |off;
      default:       ld_fault = 1'b1;
    endcase
  endfunction

  function automatic logic st_fault(logic [2:0] size, logic [1:0] off);
    case (size)
      MEM_B:   st_fault = 1'b0;
      MEM_H:   st_fault = off[0];
      MEM_W:   st_fault = |off;
      default: st_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core data-memory port plus MMIO peripheral bus, as seen by the responder.
interface data_mem_responder_if;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  MemSize;
  logic [31:0] A_Ram;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        io_rd;
  logic        io_wr;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [3:0]  io_be;
  logic [31:0] io_rdata;
  logic        mis_err;
  logic [31:0] mis_addr;

  modport slave (
    input  MemRead, MemWrite, MemSize, A_Ram, WriteData, io_rdata,
    output ReadData, io_rd, io_wr, io_addr, io_wdata, io_be, mis_err, mis_addr
  );

  modport master (
    output MemRead, MemWrite, MemSize, A_Ram, WriteData, io_rdata,
    input  ReadData, io_rd, io_wr, io_addr, io_wdata, io_be, mis_err, mis_addr
  );
endinterface

// File: rtl/bram_be_sp.sv
// Single-port word RAM with per-byte write enables and a read-first output
// register that only updates on a read.
module bram_be_sp #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) dout <= mem[addr];
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: BRAM/MMIO region decode, store lane steering,
// one-cycle load response with extension, sticky misalignment trap.
module data_mem_responder
  import soc_mem_pkg::*;
#(
  parameter int         DEPTH_WORDS = 1024,
  parameter logic [7:0] IO_TOP8     = IO_TOP8_DEF
) (
  input  logic clk,
  input  logic reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [1:0]  off;
  logic        io_sel, ld_bad, st_bad, rd_ok, wr_ok;
  logic [3:0]  be, ram_we;
  logic [31:0] wdata, ram_word;

  assign off    = bus.A_Ram[1:0];
  assign io_sel = (bus.A_Ram[31:24] == IO_TOP8);
  assign ld_bad = bus.MemRead  & ld_fault(bus.MemSize, off);
  assign st_bad = bus.MemWrite & st_fault(bus.MemSize, off);
  assign rd_ok  = bus.MemRead  & ~ld_bad;
  assign wr_ok  = bus.MemWrite & ~st_bad;
  assign be     = store_be(bus.MemSize, off);
  assign wdata  = store_data(bus.MemSize, bus.WriteData);
  assign ram_we = (wr_ok & ~io_sel) ? be : 4'b0000;

  bram_be_sp #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk  (clk),
    .re   (bus.MemRead),
    .we   (ram_we),
    .addr (bus.A_Ram[AW+1:2]),
    .din  (wdata),
    .dout (ram_word)
  );

  assign bus.io_rd    = rd_ok & io_sel;
  assign bus.io_wr    = wr_ok & io_sel;
  assign bus.io_addr  = bus.A_Ram;
  assign bus.io_wdata = wdata;
  assign bus.io_be    = (bus.io_rd | bus.io_wr) ? be : 4'b0000;

  // One-deep response register; vld_q keeps ReadData at 0 until the first
  // load after reset since the BRAM output register itself is not reset.
  logic        vld_q, io_q, bad_q;
  logic [2:0]  size_q;
  logic [1:0]  off_q;
  logic [31:0] io_word_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q     <= 1'b0;
      io_q      <= 1'b0;
      bad_q     <= 1'b0;
      size_q    <= 3'b000;
      off_q     <= 2'b00;
      io_word_q <= 32'b0;
    end else if (bus.MemRead) begin
      vld_q     <= 1'b1;
      io_q      <= io_sel;
      bad_q     <= ld_bad;
      size_q    <= bus.MemSize;
      off_q     <= off;
      io_word_q <= bus.io_rdata;
    end
  end

  assign bus.ReadData = (vld_q & ~bad_q)
                        ? load_extend(io_q ? io_word_q : ram_word, size_q, off_q)
                        : 32'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.mis_err  <= 1'b0;
      bus.mis_addr <= 32'b0;
    end else if (ld_bad | st_bad) begin
      bus.mis_err <= 1'b1;
      if (!bus.mis_err) bus.mis_addr <= bus.A_Ram;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed + randomized bench for data_mem_responder against a byte-level
// memory model with arithmetic alignment and extension rules.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] hold  = 32'b0;
  bit          merr  = 1'b0;
  logic [31:0] maddr = 32'b0;
  logic [7:0]  bmem [int unsigned];

  data_mem_responder_if bus ();

  data_mem_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 4 KB of RAM: higher address bits alias.
  function automatic int unsigned kb(input logic [31:0] a);
    return int'(a & 32'h0000_0FFF);
  endfunction

  function automatic bit m_fault(input bit st, input logic [2:0] sz, input logic [31:0] a);
    int w;
    if (sz == 3'd3 || sz > 3'd5 || (st && sz[2])) return 1'b1;
    w = 1 << sz[1:0];
    return (a % 32'(w)) != 0;
  endfunction

  task automatic op(input bit rd, input bit wr, input logic [2:0] sz,
                    input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ird);
    bit io, lf, sf;
    int n, o;
    longint v;
    logic [31:0] nxt;
    io = (a[31:24] == 8'hC0);
    n  = 1 << sz[1:0];
    o  = int'(a[1:0]);
    lf = rd && m_fault(1'b0, sz, a);
    sf = wr && m_fault(1'b1, sz, a);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.MemSize   = sz;
    bus.A_Ram     = a;
    bus.WriteData = wd;
    bus.io_rdata  = ird;
    #1;
    chk("io_rd", 32'(bus.io_rd), 32'(rd && io && !lf));
    chk("io_wr", 32'(bus.io_wr), 32'(wr && io && !sf));
    if ((wr && io && !sf) || (rd && io && !lf)) chk("io_addr", bus.io_addr, a);
    if (wr && io && !sf) begin
      chk("io_be", 32'(bus.io_be), 32'(((1 << n) - 1) << o));
      for (int i = 0; i < n; i++)
        chk("io_wdata_lane", 32'(bus.io_wdata[8*(o+i) +: 8]), 32'(wd[8*i +: 8]));
    end
    chk("rd_latency", bus.ReadData, hold);
    nxt = hold;
    if (rd) begin
      v = 0;
      if (!lf) begin
        for (int i = 0; i < n; i++)
          v = v | (longint'(io ? ird[8*(o+i) +: 8] : bmem[kb(a + 32'(i))]) << (8*i));
        if (sz < 3'd4 && n < 4 && v >= (longint'(1) << (8*n - 1)))
          v = v - (longint'(1) << (8*n));
      end
      nxt = v[31:0];
    end
    if ((lf || sf) && !merr) maddr = a;
    if (lf || sf) merr = 1'b1;
    @(posedge clk);
    #1;
    if (wr && !sf && !io)
      for (int i = 0; i < n; i++) bmem[kb(a + 32'(i))] = wd[8*i +: 8];
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    hold = nxt;
    chk("ReadData", bus.ReadData, hold);
    chk("mis_err", 32'(bus.mis_err), 32'(merr));
    chk("mis_addr", bus.mis_addr, maddr);
  endtask

  task automatic idle();
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    @(posedge clk);
    #1;
    chk("hold", bus.ReadData, hold);
    chk("idle_io_rd", 32'(bus.io_rd), 32'd0);
    chk("idle_io_wr", 32'(bus.io_wr), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.MemRead = 1'b0; bus.MemWrite = 1'b0; bus.MemSize = 3'd0;
    bus.A_Ram = 32'b0; bus.WriteData = 32'b0; bus.io_rdata = 32'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ReadData", bus.ReadData, 32'd0);
    chk("rst_mis_err", 32'(bus.mis_err), 32'd0);
    chk("rst_mis_addr", bus.mis_addr, 32'd0);
    chk("rst_io_rd", 32'(bus.io_rd), 32'd0);
    reset = 1'b0;

    // word store, then every load flavour at each lane
    op(0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0);
    op(1, 0, 3'd0, 32'h103, 0, 0); chk("LB103", bus.ReadData, 32'hFFFFFFDE);
    op(1, 0, 3'd4, 32'h103, 0, 0); chk("LBU103", bus.ReadData, 32'h000000DE);
    op(1, 0, 3'd1, 32'h102, 0, 0); chk("LH102", bus.ReadData, 32'hFFFFDEAD);
    op(1, 0, 3'd5, 32'h100, 0, 0); chk("LHU100", bus.ReadData, 32'h0000BEEF);
    op(1, 0, 3'd2, 32'h100, 0, 0); chk("LW100", bus.ReadData, 32'hDEADBEEF);
    idle();

    // partial stores into a zeroed word
    op(0, 1, 3'd2, 32'h200, 32'h0, 0);
    op(0, 1, 3'd0, 32'h201, 32'h55, 0);
    op(1, 0, 3'd2, 32'h200, 0, 0); chk("SB201", bus.ReadData, 32'h00005500);
    op(0, 1, 3'd1, 32'h202, 32'h1234, 0);
    op(1, 0, 3'd2, 32'h200, 0, 0); chk("SH202", bus.ReadData, 32'h12345500);

    // faults: first address sticks, faulting store leaves RAM untouched
    op(0, 1, 3'd2, 32'h300, 32'h77, 0);
    op(1, 0, 3'd2, 32'h102, 0, 0);
    chk("mis_rd_zero", bus.ReadData, 32'd0);
    chk("mis_err_set", 32'(bus.mis_err), 32'd1);
    op(0, 1, 3'd1, 32'h301, 32'hFFFF, 0);
    chk("mis_addr_first", bus.mis_addr, 32'h102);
    op(1, 0, 3'd2, 32'h300, 0, 0); chk("no_write_on_fault", bus.ReadData, 32'h77);

    // MMIO window
    op(0, 1, 3'd2, 32'hC000_0004, 32'hA5, 0);
    idle();
    op(1, 0, 3'd4, 32'hC000_0005, 0, 32'h0000F300); chk("io_LBU", bus.ReadData, 32'h000000F3);
    idle();

    // randomized traffic over a pre-initialized RAM window plus MMIO
    for (int w = 0; w < 64; w++) op(0, 1, 3'd2, 32'h400 + 32'(4*w), $urandom, 0);
    for (int k = 0; k < 300; k++) begin
      int kind;
      logic [2:0]  sz;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      case ($urandom_range(0, 7))
        0: sz = 3'($urandom_range(0, 7));
        1, 2: sz = 3'd0;
        3: sz = 3'd4;
        4, 5: sz = 3'd1;
        6: sz = 3'd5;
        default: sz = 3'd2;
      endcase
      if ($urandom_range(0, 3) == 0) a = {8'hC0, 24'($urandom)};
      else a = 32'h400 + 32'($urandom_range(0, 255));
      if (kind == 0) idle();
      else op(kind <= 4 || kind == 9, kind >= 5, sz, a, $urandom, $urandom);
    end

    // reset with a load response outstanding
    op(1, 0, 3'd2, 32'h100, 0, 0);
    chk("pre_reset_LW", bus.ReadData, 32'hDEADBEEF);
    reset = 1'b1;
    #1;
    chk("async_rst_ReadData", bus.ReadData, 32'd0);
    chk("async_rst_mis_err", 32'(bus.mis_err), 32'd0);
    chk("async_rst_mis_addr", bus.mis_addr, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    hold = 32'b0; merr = 1'b0; maddr = 32'b0;
    idle();
    op(1, 0, 3'd2, 32'h100, 0, 0); chk("ram_kept", bus.ReadData, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Target-side responder for the core's data-memory port.
- Services single-cycle MemRead/MemWrite strobes with MemSize taken from funct3.
- RAM accesses go to an on-chip word BRAM with byte enables; accesses in the MMIO window are forwarded to the peripheral bus.
- Performs lane steering, load sign/zero extension and misalignment trapping, so the core sees fixed one-cycle read latency.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit RAM words; RAM index = A_Ram[log2(DEPTH_WORDS)+1:2], upper bits ignored outside the IO window.
- IO_TOP8, 8'hC0, value of A_Ram[31:24] that selects the MMIO window.

Ports:
- clk  in  1  system clock.
- reset  in  1  interface: one clock; reset is asynchronous and active-high.
- MemRead  in  1  single-cycle load strobe.
- MemWrite  in  1  single-cycle store strobe.
- MemSize  in  3  funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- A_Ram  in  32  byte address.
- WriteData  in  32  store data, right-aligned.
- ReadData  out  32  extended load result.
- io_rd  out  1  MMIO read strobe.
- io_wr  out  1  MMIO write strobe.
- io_addr  out  32  MMIO byte address, equal to A_Ram.
- io_wdata  out  32  lane-steered store data.
- io_be  out  4  MMIO byte enables.
- io_rdata  in  32  MMIO read word, valid in the same cycle as io_rd.
- mis_err  out  1  sticky misaligned/illegal-access flag.
- mis_addr  out  32  address of the first faulting access.

Behaviour:
- Region decode: io_sel = (A_Ram[31:24] == IO_TOP8); all other addresses target RAM.
- Lane offset: off = A_Ram[1:0].
- Store byte enables (no error):
  - SB: be = 4'b0001 << off; data = WriteData[7:0] replicated x4.
  - SH: be = 0011 for off=00, 1100 for off=10; data = WriteData[15:0] replicated x2.
  - SW: be = 1111; data = WriteData.
- Faults:
  - Misaligned: LH/LHU/SH with off[0]=1; LW/SW with off != 0.
  - Illegal: MemSize 011, 110, 111 on a load; MemSize[2]=1 or 011 on a store.
  - On any fault: no RAM write, no io strobe, ReadData=0 on the response cycle.
  - mis_err is set; mis_addr captures A_Ram only if mis_err was previously 0.
  - Both are cleared only by reset.
- Store timing: the RAM write commits at the clk edge ending the cycle in which MemWrite=1. io_wr is asserted combinationally in that same cycle (io_sel and no fault); io_be and io_wdata are valid with it.
- Load timing:
  - MemRead=1 in cycle N: BRAM performs a synchronous read at the end of N; size, off, io_sel and fault are registered at the same edge.
  - io_rd is asserted combinationally in N; io_rdata is captured at the end of N.
  - In cycle N+1, ReadData is combinationally derived from the registered word: lane select by off, then sign-extend (LB/LH) or zero-extend (LBU/LHU) per the registered size.
  - Latency is exactly 1 cycle, matching the core's LOAD→WAIT_DATA sequence.
  - ReadData holds its value until the next MemRead. The registered word and controls update only on MemRead.
- Simultaneous MemRead and MemWrite (never issued by the core): the write commits; the read is read-first and returns the old data. Both are fault-checked independently.
- Back-to-back load then store to the same word: the load returns the pre-store value.
- Reset:
  - ReadData=0, mis_err=0, mis_addr=0, registered size/off/io_sel/fault=0.
  - io strobes are combinational and therefore 0 whenever strobes are idle.
  - RAM contents are not reset.
  - A load pending across reset is discarded; ReadData reads 0 after reset deasserts.
- Control: no FSM beyond the one-deep response register.

Decomposition:
- Shared package (soc_mem_pkg): MemSize encodings as a typed enum (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU), IO_TOP8 default, and functions store_be(size, off) and load_extend(word, size, off). The core decoder reuses these.
- Sub-module: bram_be_sp, a single-port BRAM with 4 byte enables and synchronous read-first behaviour, inferable on Artix-7.

Test Plan:
- SW 0xDEADBEEF @0x100, then LB/LBU/LH/LHU/LW @0x100..0x103 → LB@0x103 = 0xFFFFFFDE, LBU@0x103 = 0x000000DE, LH@0x102 = 0xFFFFDEAD, LHU@0x100 = 0x0000BEEF, LW = 0xDEADBEEF, each valid exactly 1 cycle after MemRead.
- SB 0x55 @0x201 over a word holding 0 → LW @0x200 = 0x00005500; SH 0x1234 @0x202 → LW = 0x12345500.
- LW @0x102, then SH @0x301 → ReadData = 0, no RAM change (LW @0x300 unchanged), mis_err=1, mis_addr=0x102 (second fault does not overwrite).
- SW 0xA5 @0xC0000004 → io_wr pulses 1 cycle, io_be=1111, io_addr=0xC0000004; LBU @0xC0000005 with io_rdata=0x0000F300 → io_rd pulses, ReadData = 0x000000F3 next cycle.
- Assert reset while a LW response is pending → ReadData=0 and mis_err=0 immediately (async); RAM word at 0x100 retains 0xDEADBEEF after reset.
